// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, func3
// access-size codes and the func3 legality helper.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Stores only have signed-size encodings; unsigned codes make no sense
  // for a write and the remaining codes are unassigned.
  function automatic logic func3_illegal(input logic [2:0] f3, input logic is_store);
    logic bad;
    bad = 1'b1;
    case (f3)
      LSU_B, LSU_H, LSU_W: bad = 1'b0;
      LSU_BU, LSU_HU:      bad = is_store;
      default:             bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering for the word-wide data bus: store strobes and lane
// replication, load extraction with sign/zero extension, misalign detect.
module lsu_ctrl_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] resp_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  // Pure lane mapping; narrow store data is replicated so every lane the
  // strobe may select already holds the right bytes.
  always_comb begin
    shifted    = resp_rdata >> {addr_lo, 3'b000};
    wstrb      = 4'b0000;
    lane_wdata = wdata;
    load_data  = resp_rdata;
    misalign   = 1'b0;
    case (func3)
      LSU_B: begin
        wstrb      = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{shifted[7]}}, shifted[7:0]};
      end
      LSU_BU: begin
        wstrb      = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {24'h0, shifted[7:0]};
      end
      LSU_H: begin
        misalign   = addr_lo[0];
        wstrb      = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {{16{shifted[15]}}, shifted[15:0]};
      end
      LSU_HU: begin
        misalign   = addr_lo[0];
        wstrb      = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {16'h0, shifted[15:0]};
      end
      LSU_W: begin
        misalign   = |addr_lo;
        wstrb      = 4'b1111;
        lane_wdata = wdata;
        load_data  = resp_rdata;
      end
      default: begin
        wstrb = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one-cycle load/store pulses from
// decode, runs a single valid/ready transaction on the data bus and returns
// finish/rvalid/error pulses with the aligned and extended load result.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_rvalid,
  output logic              mem_finish,
  output logic [31:0]       rdata,
  output logic              lsu_err,
  output logic              busy,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [31:0]       bus_resp_rdata,
  output logic              bus_resp_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t        state;
  lsu_state_t        next_state;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              store_q;
  logic              dual_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic        go;
  logic        illegal;
  logic        timed_out;
  logic        fail_now;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misalign;

  lsu_ctrl_align u_align (
    .func3      (func3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .resp_rdata (bus_resp_rdata),
    .wstrb      (al_wstrb),
    .lane_wdata (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  assign go        = mem_read | mem_write;
  assign illegal   = dual_q | al_misalign | func3_illegal(func3_q, store_q);
  assign timed_out = (wait_cnt == CNT_LAST);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LSU_IDLE;
    else      state <= next_state;
  end

  // Next state; legality is judged on the captured request during the first
  // REQ cycle, so an illegal access leaves REQ without ever raising valid.
  always_comb begin
    next_state = state;
    fail_now   = 1'b0;
    case (state)
      LSU_IDLE: if (go) next_state = LSU_REQ;
      LSU_REQ: begin
        if (illegal) begin
          next_state = LSU_DONE;
          fail_now   = 1'b1;
        end else if (bus_req_ready) begin
          next_state = LSU_RESP;
        end else if (timed_out) begin
          next_state = LSU_DONE;
          fail_now   = 1'b1;
        end
      end
      LSU_RESP: begin
        if (bus_resp_valid) begin
          next_state = LSU_DONE;
        end else if (timed_out) begin
          next_state = LSU_DONE;
          fail_now   = 1'b1;
        end
      end
      LSU_DONE: next_state = LSU_IDLE;
      default:  next_state = LSU_IDLE;
    endcase
  end

  // Outputs are a pure function of state; bus fields read zero when idle.
  always_comb begin
    bus_req_valid  = (state == LSU_REQ) && !illegal;
    bus_req_we     = bus_req_valid && store_q;
    bus_req_addr   = bus_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus_req_wdata  = bus_req_we ? al_wdata : 32'h0;
    bus_req_wstrb  = bus_req_we ? al_wstrb : 4'h0;
    bus_resp_ready = (state == LSU_RESP);
    busy           = (state != LSU_IDLE);
    mem_finish     = (state == LSU_DONE);
    mem_rvalid     = (state == LSU_DONE) && !store_q && !err_q;
    lsu_err        = (state == LSU_DONE) && err_q;
  end

  // Capture the request only when idle; pulses during an access are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      func3_q <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      store_q <= 1'b0;
      dual_q  <= 1'b0;
    end else if (state == LSU_IDLE && go) begin
      func3_q <= func3;
      addr_q  <= addr;
      wdata_q <= wdata;
      store_q <= mem_write;
      dual_q  <= mem_read & mem_write;
    end
  end

  // Wait counter measures time spent in one bus phase and restarts per phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (next_state != state || (state != LSU_REQ && state != LSU_RESP))
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Error flag is cleared per access and set by any abort path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           err_q <= 1'b0;
    else if (state == LSU_IDLE && go)   err_q <= 1'b0;
    else if (fail_now)                  err_q <= 1'b1;
  end

  // Load result is held between accesses and zeroed whenever an access fails.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rdata <= 32'h0;
    else if (fail_now)
      rdata <= 32'h0;
    else if (state == LSU_RESP && bus_resp_valid && !store_q)
      rdata <= al_load;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: table of single accesses with a one-cycle
// late bus, plus timeout and asynchronous-reset sequences.
module tb_lsu_ctrl;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic        err;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] ldata;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_rvalid;
  logic        mem_finish;
  logic [31:0] rdata;
  logic        lsu_err;
  logic        busy;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;
  logic        bus_resp_ready;

  int          total;
  int          bad;
  logic [31:0] model_rdata;
  vec_t        vecs[13];

  lsu_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .func3          (func3),
    .addr           (addr),
    .wdata          (wdata),
    .mem_rvalid     (mem_rvalid),
    .mem_finish     (mem_finish),
    .rdata          (rdata),
    .lsu_err        (lsu_err),
    .busy           (busy),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_we     (bus_req_we),
    .bus_req_addr   (bus_req_addr),
    .bus_req_wdata  (bus_req_wdata),
    .bus_req_wstrb  (bus_req_wstrb),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_rdata (bus_resp_rdata),
    .bus_resp_ready (bus_resp_ready)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"},       {31'h0, busy},           32'h0);
    checkOutput({tag, " req_valid"},  {31'h0, bus_req_valid},  32'h0);
    checkOutput({tag, " resp_ready"}, {31'h0, bus_resp_ready}, 32'h0);
    checkOutput({tag, " finish"},     {31'h0, mem_finish},     32'h0);
    checkOutput({tag, " rvalid"},     {31'h0, mem_rvalid},     32'h0);
    checkOutput({tag, " err"},        {31'h0, lsu_err},        32'h0);
    checkOutput({tag, " req_addr"},   bus_req_addr,            32'h0);
    checkOutput({tag, " req_wstrb"},  {28'h0, bus_req_wstrb},  32'h0);
  endtask

  // One access: pulse, bus accepts one cycle later, responds one cycle after that.
  task automatic applyStimulus(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    mem_read  = v.rd;
    mem_write = v.wr;
    func3     = v.f3;
    addr      = v.addr;
    wdata     = v.wdata;
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    checkOutput({t, " busy"}, {31'h0, busy}, 32'h1);
    if (v.err) begin
      checkOutput({t, " no_valid"}, {31'h0, bus_req_valid}, 32'h0);
      @(negedge clk);
      model_rdata = 32'h0;
      checkOutput({t, " finish"},   {31'h0, mem_finish},    32'h1);
      checkOutput({t, " err"},      {31'h0, lsu_err},       32'h1);
      checkOutput({t, " rvalid"},   {31'h0, mem_rvalid},    32'h0);
      checkOutput({t, " no_valid2"},{31'h0, bus_req_valid}, 32'h0);
      checkOutput({t, " rdata"},    rdata,                  model_rdata);
    end else begin
      checkOutput({t, " valid"}, {31'h0, bus_req_valid}, 32'h1);
      checkOutput({t, " we"},    {31'h0, bus_req_we},    {31'h0, v.wr});
      checkOutput({t, " addr"},  bus_req_addr,           {v.addr[31:2], 2'b00});
      checkOutput({t, " wstrb"}, {28'h0, bus_req_wstrb}, {28'h0, v.strb});
      checkOutput({t, " wdata"}, bus_req_wdata,          v.bwdata);
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0;
      checkOutput({t, " valid_drop"}, {31'h0, bus_req_valid},  32'h0);
      checkOutput({t, " resp_ready"}, {31'h0, bus_resp_ready}, 32'h1);
      checkOutput({t, " early_fin"},  {31'h0, mem_finish},     32'h0);
      bus_resp_valid = 1'b1;
      bus_resp_rdata = v.resp;
      @(negedge clk);
      bus_resp_valid = 1'b0;
      bus_resp_rdata = 32'h0;
      if (v.rd) model_rdata = v.ldata;
      checkOutput({t, " finish"}, {31'h0, mem_finish}, 32'h1);
      checkOutput({t, " rvalid"}, {31'h0, mem_rvalid}, {31'h0, v.rd});
      checkOutput({t, " err"},    {31'h0, lsu_err},    32'h0);
      checkOutput({t, " rdata"},  rdata,               model_rdata);
    end
    @(negedge clk);
    checkOutput({t, " fin_pulse"}, {31'h0, mem_finish}, 32'h0);
    checkOutput({t, " idle"},      {31'h0, busy},       32'h0);
    checkOutput({t, " rdata_hold"}, rdata,              model_rdata);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    model_rdata    = 32'h0;
    rst            = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    func3          = 3'b000;
    addr           = 32'h0;
    wdata          = 32'h0;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;

    //            rd    wr    f3      addr          wdata         resp          err   strb     bwdata        ldata
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h80000004, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 4'b0000, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h80000002, 32'h0,        32'h80FF1234, 1'b0, 4'b0000, 32'h0,        32'hFFFF80FF};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h80000000, 32'h0,        32'h80FF1234, 1'b0, 4'b0000, 32'h0,        32'h00001234};
    vecs[5]  = '{1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h80000001, 32'h123456A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h80000008, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h80000001, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h80000003, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h80000000, 32'h11,       32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h80000000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h80000000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

    repeat (3) @(negedge clk);
    checkIdle("reset_hold");
    checkOutput("reset_rdata", rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkIdle("after_reset");

    // Table of single accesses.
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Timeout in REQ with a second pulse arriving while busy.
    $display("[TB] timeout sequence");
    model_rdata = 32'hDEADBEEF;
    applyStimulus(vecs[0], 100);
    @(negedge clk);
    mem_read = 1'b1;
    func3    = 3'b010;
    addr     = 32'h80000010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mem_read = 1'b0;
      if (c == 2) begin
        mem_write = 1'b1;
        func3     = 3'b010;
        addr      = 32'h80000020;
        wdata     = 32'h55555555;
      end else begin
        mem_write = 1'b0;
      end
      checkOutput($sformatf("to c%0d valid", c), {31'h0, bus_req_valid}, 32'h1);
      checkOutput($sformatf("to c%0d addr", c),  bus_req_addr,           32'h80000010);
      checkOutput($sformatf("to c%0d finish", c),{31'h0, mem_finish},    32'h0);
    end
    @(negedge clk);
    mem_write   = 1'b0;
    model_rdata = 32'h0;
    checkOutput("to finish", {31'h0, mem_finish},    32'h1);
    checkOutput("to err",    {31'h0, lsu_err},       32'h1);
    checkOutput("to valid",  {31'h0, bus_req_valid}, 32'h0);
    checkOutput("to rvalid", {31'h0, mem_rvalid},    32'h0);
    checkOutput("to rdata",  rdata,                  model_rdata);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdle($sformatf("to_after%0d", c));
    end

    // Asynchronous reset while waiting for the response.
    $display("[TB] reset-in-resp sequence");
    applyStimulus(vecs[0], 200);
    @(negedge clk);
    mem_read = 1'b1;
    func3    = 3'b010;
    addr     = 32'h80000004;
    @(negedge clk);
    mem_read      = 1'b0;
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    checkOutput("rr resp_ready", {31'h0, bus_resp_ready}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    checkIdle("rr_async");
    checkOutput("rr rdata", rdata, 32'h0);
    model_rdata = 32'h0;
    @(negedge clk);
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h12345678;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    checkIdle("rr_held");
    rst = 1'b1;
    applyStimulus(vecs[7], 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit controller directly downstream of the decode stage in the multicycle core.
- Consumes the single-cycle mem_read/mem_write request pulses plus func3, address and store data.
- Drives a word-wide valid/ready data-memory bus, performs byte-lane alignment and sign/zero extension, and returns mem_rvalid/mem_finish pulses to decode and writeback.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT, 255, max cycles waiting for req_ready or resp_valid before aborting with error

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
mem_read  in  1  one-cycle load request pulse
mem_write  in  1  one-cycle store request pulse
func3  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010)
addr  in  ADDR_W  byte address (rs1+imm from EXU)
wdata  in  32  store data (rs2), LSB-aligned
mem_rvalid  out  1  one-cycle pulse: rdata valid (loads only)
mem_finish  out  1  one-cycle pulse: access complete (load, store or error)
rdata  out  32  extended load result, held until next access
lsu_err  out  1  one-cycle pulse with mem_finish on misalign/timeout/illegal func3
busy  out  1  high from accepted request until mem_finish cycle inclusive
bus_req_valid  out  1  memory request valid
bus_req_ready  in  1  memory accepts request
bus_req_we  out  1  1 = write
bus_req_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0)
bus_req_wdata  out  32  store data shifted to byte lane
bus_req_wstrb  out  4  byte enables
bus_resp_valid  in  1  response valid (read data or write ack)
bus_resp_rdata  in  32  read word
bus_resp_ready  out  1  high only in S_RESP

Behaviour:
- Reset: state S_IDLE; all outputs 0, rdata 0, timeout counter 0. Reset mid-access abandons the transaction immediately; no finish pulse.
- States: S_IDLE, S_REQ, S_RESP, S_DONE.
- S_IDLE: on mem_read^mem_write, capture func3, addr, wdata, direction; check legality.
  - Legal -> S_REQ next cycle (bus_req_valid rises cycle N+1 after pulse at N).
  - Illegal -> S_DONE with err flag set.
- Legality:
  - half access needs addr[0]==0; word access needs addr[1:0]==0.
  - func3 011/110/111 illegal; 100/101 illegal for stores.
  - mem_read and mem_write both high in the same cycle is illegal.
- S_REQ: bus_req_* held stable while valid; on valid&&ready -> S_RESP.
- S_RESP: bus_resp_ready=1; on bus_resp_valid, latch extended data (loads) -> S_DONE. Response accepted in the same cycle the request handshakes is not permitted; bus response earliest one cycle after request handshake.
- S_DONE: one cycle; mem_finish=1; mem_rvalid=1 iff load and no error; lsu_err=err flag; -> S_IDLE.
- Minimum latency: pulse at N, ready at N+1, resp at N+2 -> finish at N+3.
- Timeout: counter counts cycles in S_REQ/S_RESP, clears on each state change; reaching TIMEOUT -> S_DONE with err, bus_req_valid dropped.
- Errors: on error, rdata is forced to 0.
- Requests while not S_IDLE are ignored (decode guarantees one outstanding access).
- Store lanes:
  - sb: wstrb = 1<<addr[1:0], wdata byte replicated to all lanes.
  - sh: wstrb = 0011<<addr[1:0], wdata half replicated.
  - sw: wstrb = 1111.
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]); half = rdata >> (8*addr[1:0]).
  - Sign-extend for lb/lh; zero-extend for lbu/lhu.
- busy: high in S_REQ, S_RESP, S_DONE.

Decomposition:
- Shared package (utils): state encodings LSU_IDLE/REQ/RESP/DONE; func3 size constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
- One combinational sub-module, lsu_align: captured func3, addr[1:0], wdata, bus_resp_rdata in; wstrb, lane-shifted wdata, extended load data and misalign flag out. Reused by later cache work.

Test Plan:
- lw: mem_read, addr 0x80000004, bus returns 0xDEADBEEF with ready/resp each one cycle late -> bus_req_addr 0x80000004, mem_rvalid+mem_finish together at N+3, rdata 0xDEADBEEF.
- lb/lbu: addr 0x80000003, word 0x80FF1234 -> lb rdata 0xFFFFFF80, lbu rdata 0x00000080.
- sh: addr 0x80000002, wdata 0x0000ABCD -> we=1, wstrb 1100, wdata 0xABCDABCD; finish without mem_rvalid.
- Misaligned lw at 0x80000001 -> no bus_req_valid ever; finish+lsu_err at N+2, rdata 0.
- TIMEOUT=4, bus_req_ready held 0 -> bus_req_valid drops, lsu_err+finish after 4 wait cycles; a second pulse during busy is ignored.
- rst pulled low while in S_RESP -> all outputs 0 asynchronously; after release, a new sw completes normally.
